// File: rtl/conv_bin_bcd_corriente_pkg.sv
// Shared widths and FSM encoding for the binary-to-BCD setpoint converter.
package conv_bin_bcd_corriente_pkg;
  localparam int ANCHO_BIN = 10;
  localparam int NUM_DIG   = 4;
  localparam int ANCHO_CNT = $clog2(ANCHO_BIN);
  localparam int ANCHO_BCD = 4 * NUM_DIG;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } estado_t;
endpackage

// File: rtl/conv_bin_bcd_corriente_ajuste.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module ajuste_bcd_dig (
  input  logic [3:0] dig,
  output logic [3:0] ajustado
);
  assign ajustado = (dig >= 4'd5) ? dig + 4'd3 : dig;
endmodule

// File: rtl/conv_bin_bcd_corriente.sv
// Iterative binary-to-BCD converter for the current setpoint, one bit per clock.
// Reconverts whenever valor changes or a request arrives; outputs change only at DONE.
module conv_bin_bcd_corriente
  import conv_bin_bcd_corriente_pkg::*;
(
  input  logic                 clk_nx,
  input  logic                 rst,
  input  logic [ANCHO_BIN-1:0] valor,
  input  logic                 conv_req,
  output logic [3:0]           bcd_mil,
  output logic [3:0]           bcd_cen,
  output logic [3:0]           bcd_dec,
  output logic [3:0]           bcd_uni,
  output logic                 ocupado,
  output logic                 listo
);
  estado_t              estado_reg, estado_next;
  logic [ANCHO_BIN-1:0] bin_reg, bin_next;
  logic [ANCHO_BIN-1:0] captura_reg, captura_next;
  logic [ANCHO_BIN-1:0] valor_prev_reg, valor_prev_next;
  logic [ANCHO_BCD-1:0] scratch_reg, scratch_next;
  logic [ANCHO_BCD-1:0] salida_reg, salida_next;
  logic [ANCHO_CNT-1:0] cnt_reg, cnt_next;
  logic                 pendiente_reg, pendiente_next;
  logic                 ocupado_reg, ocupado_next;
  logic                 listo_reg, listo_next;
  logic [ANCHO_BCD-1:0] ajustado;
  logic                 disparo;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIG; gi++) begin : g_ajuste
      ajuste_bcd_dig u_ajuste (
        .dig      (scratch_reg[4*gi +: 4]),
        .ajustado (ajustado[4*gi +: 4])
      );
    end
  endgenerate

  assign disparo = (valor != valor_prev_reg) || conv_req || pendiente_reg;

  always_ff @(posedge clk_nx or posedge rst) begin
    if (rst) begin
      estado_reg     <= IDLE;
      bin_reg        <= '0;
      captura_reg    <= '0;
      valor_prev_reg <= '0;
      scratch_reg    <= '0;
      salida_reg     <= '0;
      cnt_reg        <= '0;
      pendiente_reg  <= 1'b1;
      ocupado_reg    <= 1'b0;
      listo_reg      <= 1'b0;
    end else begin
      estado_reg     <= estado_next;
      bin_reg        <= bin_next;
      captura_reg    <= captura_next;
      valor_prev_reg <= valor_prev_next;
      scratch_reg    <= scratch_next;
      salida_reg     <= salida_next;
      cnt_reg        <= cnt_next;
      pendiente_reg  <= pendiente_next;
      ocupado_reg    <= ocupado_next;
      listo_reg      <= listo_next;
    end
  end

  always_comb begin
    estado_next     = estado_reg;
    bin_next        = bin_reg;
    captura_next    = captura_reg;
    valor_prev_next = valor_prev_reg;
    scratch_next    = scratch_reg;
    salida_next     = salida_reg;
    cnt_next        = cnt_reg;
    pendiente_next  = pendiente_reg;
    ocupado_next    = ocupado_reg;
    listo_next      = 1'b0;

    // Requests arriving while busy are remembered and collapse into one rerun.
    if (estado_reg != IDLE && conv_req) begin
      pendiente_next = 1'b1;
    end

    case (estado_reg)
      IDLE: begin
        ocupado_next = 1'b0;
        if (disparo) begin
          bin_next       = valor;
          captura_next   = valor;
          scratch_next   = '0;
          cnt_next       = '0;
          pendiente_next = 1'b0;
          ocupado_next   = 1'b1;
          estado_next    = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_next, bin_next} = {ajustado, bin_reg} << 1;
        cnt_next = cnt_reg + ANCHO_CNT'(1);
        if (cnt_reg == ANCHO_CNT'(ANCHO_BIN - 1)) begin
          estado_next = DONE;
        end
      end
      DONE: begin
        salida_next     = scratch_reg;
        valor_prev_next = captura_reg;
        listo_next      = 1'b1;
        ocupado_next    = 1'b0;
        estado_next     = IDLE;
      end
      default: begin
        estado_next = IDLE;
      end
    endcase
  end

  assign bcd_uni = salida_reg[3:0];
  assign bcd_dec = salida_reg[7:4];
  assign bcd_cen = salida_reg[11:8];
  assign bcd_mil = salida_reg[15:12];
  assign ocupado = ocupado_reg;
  assign listo   = listo_reg;
endmodule

// File: tb/tb_conv_bin_bcd_corriente.sv
// Self-checking bench: digit values from plain decimal arithmetic, timing from the latency rules.
module tb_conv_bin_bcd_corriente;
  logic       clk_nx = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] valor = '0;
  logic       conv_req = 1'b0;
  logic [3:0] bcd_mil, bcd_cen, bcd_dec, bcd_uni;
  logic       ocupado, listo;
  logic [15:0] digitos;

  int checks = 0;
  int failures = 0;

  conv_bin_bcd_corriente dut (
    .clk_nx   (clk_nx),
    .rst      (rst),
    .valor    (valor),
    .conv_req (conv_req),
    .bcd_mil  (bcd_mil),
    .bcd_cen  (bcd_cen),
    .bcd_dec  (bcd_dec),
    .bcd_uni  (bcd_uni),
    .ocupado  (ocupado),
    .listo    (listo)
  );

  always #5 clk_nx = ~clk_nx;
  assign digitos = {bcd_mil, bcd_cen, bcd_dec, bcd_uni};

  function automatic logic [15:0] modelo_bcd(input int v);
    int m, c, d, u;
    m = (v / 1000) % 10;
    c = (v / 100) % 10;
    d = (v / 10) % 10;
    u = v % 10;
    return {m[3:0], c[3:0], d[3:0], u[3:0]};
  endfunction

  // One clock; observation happens on the falling edge.
  task automatic tick();
    @(posedge clk_nx);
    @(negedge clk_nx);
  endtask

  // Advance until listo is seen (bounded); report cycles used and whether digits moved early.
  task automatic wait_listo(input int max, output int cycles, output bit glitch);
    logic [15:0] inicial;
    inicial = digitos;
    glitch = 1'b0;
    cycles = 0;
    while (cycles <= max) begin
      tick();
      cycles++;
      if (listo) break;
      if (digitos !== inicial) glitch = 1'b1;
    end
  endtask

  task automatic count_listo(input int n, output int pulsos);
    pulsos = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (listo) pulsos++;
    end
  endtask

  task automatic test_reset();
    int cyc; bit gl; int p;
    valor = 10'd501;
    rst = 1'b1;
    repeat (2) @(negedge clk_nx);
    checks++;
    if (digitos !== 16'h0 || ocupado !== 1'b0 || listo !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: digits=%h ocupado=%b listo=%b required 0000/0/0", digitos, ocupado, listo);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ocupado !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_edge_ocupado: got %b required 1", ocupado);
    end
    wait_listo(40, cyc, gl);
    checks++;
    if (cyc !== 11) begin
      failures++;
      $display("FAIL reset_latency: got %0d cycles required 11", cyc);
    end
    checks++;
    if (digitos !== modelo_bcd(501)) begin
      failures++;
      $display("FAIL reset_digits: got %h required %h", digitos, modelo_bcd(501));
    end
    tick();
    checks++;
    if (listo !== 1'b0 || ocupado !== 1'b0) begin
      failures++;
      $display("FAIL reset_listo_single: listo=%b ocupado=%b required 0/0", listo, ocupado);
    end
    count_listo(30, p);
    checks++;
    if (p !== 0) begin
      failures++;
      $display("FAIL reset_no_spurious_listo: got %0d pulses required 0", p);
    end
    $display("txn reset valor=501 digits=%h", digitos);
  endtask

  task automatic convert_and_check(input int v, input string nombre);
    int cyc; bit gl;
    valor = v[9:0];
    tick();
    checks++;
    if (ocupado !== 1'b1) begin
      failures++;
      $display("FAIL %s_ocupado: got %b required 1", nombre, ocupado);
    end
    wait_listo(40, cyc, gl);
    checks++;
    if (cyc !== 11 || gl !== 1'b0) begin
      failures++;
      $display("FAIL %s_timing: cycles=%0d glitch=%b required 11/0", nombre, cyc, gl);
    end
    checks++;
    if (digitos !== modelo_bcd(v)) begin
      failures++;
      $display("FAIL %s_digits: valor=%0d got %h required %h", nombre, v, digitos, modelo_bcd(v));
    end
    tick();
    $display("txn %s valor=%0d digits=%h", nombre, v, digitos);
  endtask

  task automatic test_boundaries();
    convert_and_check(950, "b950");
    convert_and_check(1000, "b1000");
    convert_and_check(0, "b0");
    convert_and_check(1023, "b1023");
    convert_and_check(9, "b9");
  endtask

  task automatic test_random();
    int v, prev;
    prev = int'(valor);
    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 1023));
      if (v == prev) v = (v + 1) % 1024;
      convert_and_check(v, "rand");
      prev = v;
    end
  endtask

  task automatic test_change_during();
    int cyc; bit gl;
    valor = 10'd550;
    tick();
    repeat (5) tick();
    valor = 10'd600;
    wait_listo(40, cyc, gl);
    checks++;
    if (cyc !== 6 || digitos !== modelo_bcd(550)) begin
      failures++;
      $display("FAIL change_first: cycles=%0d digits=%h required 6/%h", cyc, digitos, modelo_bcd(550));
    end
    tick();
    checks++;
    if (ocupado !== 1'b1 || listo !== 1'b0) begin
      failures++;
      $display("FAIL change_restart: ocupado=%b listo=%b required 1/0", ocupado, listo);
    end
    wait_listo(40, cyc, gl);
    checks++;
    if (cyc + 1 !== 12 || digitos !== modelo_bcd(600) || gl !== 1'b0) begin
      failures++;
      $display("FAIL change_second: gap=%0d digits=%h glitch=%b required 12/%h/0", cyc + 1, digitos, gl, modelo_bcd(600));
    end
    tick();
    $display("txn change valor=550->600 digits=%h", digitos);
  endtask

  task automatic test_conv_req();
    int cyc, p; bit gl;
    convert_and_check(250, "pre250");
    conv_req = 1'b1;
    tick();
    conv_req = 1'b0;
    checks++;
    if (ocupado !== 1'b1) begin
      failures++;
      $display("FAIL req_ocupado: got %b required 1", ocupado);
    end
    wait_listo(40, cyc, gl);
    checks++;
    if (cyc !== 11 || gl !== 1'b0 || digitos !== modelo_bcd(250)) begin
      failures++;
      $display("FAIL req_single: cycles=%0d glitch=%b digits=%h required 11/0/%h", cyc, gl, digitos, modelo_bcd(250));
    end
    tick();
    // Start a conversion, then fire two more requests while it runs.
    conv_req = 1'b1;
    tick();
    conv_req = 1'b0;
    repeat (2) tick();
    conv_req = 1'b1;
    tick();
    conv_req = 1'b0;
    tick();
    conv_req = 1'b1;
    tick();
    conv_req = 1'b0;
    wait_listo(40, cyc, gl);
    checks++;
    if (cyc + 5 !== 11) begin
      failures++;
      $display("FAIL req_double_first: total=%0d required 11", cyc + 5);
    end
    count_listo(40, p);
    checks++;
    if (p !== 1 || digitos !== modelo_bcd(250)) begin
      failures++;
      $display("FAIL req_double_collapse: pulses=%0d digits=%h required 1/%h", p, digitos, modelo_bcd(250));
    end
    $display("txn conv_req valor=250 extra_conversions=%0d digits=%h", p, digitos);
  endtask

  task automatic test_async_reset();
    int cyc; bit gl;
    valor = 10'd777;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (digitos !== 16'h0 || ocupado !== 1'b0 || listo !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: digits=%h ocupado=%b listo=%b required 0000/0/0", digitos, ocupado, listo);
    end
    @(negedge clk_nx);
    @(negedge clk_nx);
    rst = 1'b0;
    tick();
    checks++;
    if (ocupado !== 1'b1) begin
      failures++;
      $display("FAIL async_restart: ocupado=%b required 1", ocupado);
    end
    wait_listo(40, cyc, gl);
    checks++;
    if (cyc !== 11 || digitos !== modelo_bcd(777)) begin
      failures++;
      $display("FAIL async_reconvert: cycles=%0d digits=%h required 11/%h", cyc, digitos, modelo_bcd(777));
    end
    $display("txn async_reset valor=777 digits=%h", digitos);
  endtask

  initial begin
    @(negedge clk_nx);
    test_reset();
    test_boundaries();
    test_random();
    test_change_during();
    test_conv_req();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
